pc_ir_unit: RTL and testbench
=============================

Name: pc_ir_unit

Overview:
- Fetch-side register stage of the multicycle CPU.
- Holds the program counter (PC), instruction register (IR) and ALU-result register (ALUOut).
- Drives the opcode into the control FSM and instruction fields into the datapath.
- Consumes the FSM's PCWrite, PCWriteCond, PCSource, IRWrite and Instr26 strobes, plus the ALU result and zero flag, to sequence the PC.

Parameters:
- ADDR_W, 16: PC and instruction-memory address width.
- RESET_PC, 0: PC value loaded on reset.
- CNT_W, 32: retired-instruction counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- PCWrite  in  1  unconditional PC load enable.
- PCWriteCond  in  1  conditional (branch) PC load enable.
- PCSource  in  2  PC next-value select.
- IRWrite  in  1  IR load enable.
- Instr26  in  1  branch sense: 0 = taken on zero, 1 = taken on non-zero.
- imem_data  in  32  instruction memory read data at imem_addr.
- alu_result  in  32  combinational ALU output.
- alu_zero  in  1  ALU zero flag.
- imem_addr  out  ADDR_W  equals PC.
- pc  out  ADDR_W  current PC, feeds ALU source A select 0.
- opcode  out  6  IR[31:26].
- rs  out  5  IR[25:21].
- rt  out  5  IR[20:16].
- rd  out  5  IR[15:11].
- imm  out  16  IR[15:0].
- alu_out  out  32  registered ALU result.
- branch_taken  out  1  combinational PC-load decision.
- instr_count  out  CNT_W  count of IR loads.
- pcsrc_err  out  1  sticky illegal-PCSource flag.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - pc = RESET_PC; IR = 0, so opcode = 000000 (NOOP); alu_out = 0; instr_count = 0; pcsrc_err = 0.
  - All registered outputs hold reset values while reset is low.
  - Reset asserted mid-instruction discards all state; there is no partial update.
- Release: the first rising edge after reset rises is the first active edge.
- ALUOut: alu_out <= alu_result on every rising edge, unconditionally. This gives one-cycle latency, so a branch target computed in decode is available in the branch-execute state.
- IR: on a rising edge with IRWrite=1, IR <= imem_data and instr_count <= instr_count+1 (wraps at 2^CNT_W). Otherwise IR holds. Decoded fields are combinational slices of IR.
- Next-PC select, by PCSource:
  - 0: alu_result[ADDR_W-1:0] (PC+1 path).
  - 1: alu_out[ADDR_W-1:0] (branch target).
  - 2: IR[ADDR_W-1:0] (jump target, zero-extended/truncated to ADDR_W).
  - 3: illegal.
- Branch decision: branch_taken = PCWriteCond & (alu_zero ^ Instr26).
- PC load enable: pc_en = PCWrite | branch_taken.
  - PCWrite=1 with PCWriteCond=1: the load is unconditional (PCWrite dominates).
- PC update: on a rising edge with pc_en=1 and PCSource≠3, pc <= selected value. Any address wraps modulo 2^ADDR_W.
- Illegal select: pc_en=1 with PCSource=3 leaves pc unchanged and sets pcsrc_err=1. pcsrc_err clears only on reset.
- IRWrite and PCWrite in the same cycle (fetch state): the IR captures imem_data addressed by the old PC, and the PC advances. Both updates occur on the same edge.
- imem_addr = pc; instruction memory is combinational read.
- No internal FSM beyond the registers above. All sequencing comes from the control FSM strobes, so the block reacts within the same edge the strobe is sampled.

Test Plan:
- Reset: hold reset=0, toggle clock with PCWrite=1 -> pc=RESET_PC=0, opcode=0, instr_count=0, alu_out=0. Reassert reset mid-cycle after pc=5 -> pc returns to 0 immediately, without a clock edge.
- Fetch: pc=0x0010, imem_data=0x48A30007, alu_result=0x11, IRWrite=1, PCWrite=1, PCSource=0 -> after one edge: pc=0x0011, opcode=010010, rs=5, rt=3, imm=0x0007, instr_count=1.
- Branch select and sense: cycle 1 alu_result=0x0040 (captured into alu_out). Cycle 2 PCWriteCond=1, PCSource=1:
  - Instr26=0, alu_zero=1 -> pc=0x0040.
  - Instr26=0, alu_zero=0 -> pc unchanged.
  - Instr26=1, alu_zero=0 -> pc=0x0040.
- Jump: IR=0x04001234, PCWrite=1, PCSource=2 -> pc=0x1234. Same with ADDR_W=8 -> pc=0x34.
- Wrap and illegal select:
  - pc=0xFFFF, alu_result=0x10000, PCWrite=1, PCSource=0 -> pc=0x0000.
  - PCWrite=1, PCSource=3 -> pc held, pcsrc_err=1. pcsrc_err stays 1 across further valid updates until reset.
- Priority: PCWrite=1, PCWriteCond=1, alu_zero=0, Instr26=0, PCSource=0, alu_result=0x22 -> pc=0x0022 (branch_taken=0 but load occurs).

Source files
------------

// File: rtl/pc_ir_unit.sv
// Fetch-side register stage of the multicycle CPU: PC, IR and ALUOut registers,
// PC sequencing from the control FSM strobes, and a retired-instruction counter.
module pc_ir_unit #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              PCWrite,
  input  logic              PCWriteCond,
  input  logic [1:0]        PCSource,
  input  logic              IRWrite,
  input  logic              Instr26,
  input  logic [31:0]       imem_data,
  input  logic [31:0]       alu_result,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm,
  output logic [31:0]       alu_out,
  output logic              branch_taken,
  output logic [CNT_W-1:0]  instr_count,
  output logic              pcsrc_err
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       alu_out_q;
  logic [CNT_W-1:0]  instr_count_q, instr_count_d;
  logic              pcsrc_err_q, pcsrc_err_d;
  logic              pc_en;

  // Zero-extended copies so any ADDR_W (narrower or wider than 32) slices cleanly.
  logic [ADDR_W+31:0] alu_result_ext, alu_out_ext, ir_ext;
  logic               unused_ext;

  assign alu_result_ext = {{ADDR_W{1'b0}}, alu_result};
  assign alu_out_ext    = {{ADDR_W{1'b0}}, alu_out_q};
  assign ir_ext         = {{ADDR_W{1'b0}}, ir_q};
  assign unused_ext     = ^{alu_result_ext, alu_out_ext, ir_ext};

  always_comb begin
    branch_taken  = PCWriteCond & (alu_zero ^ Instr26);
    pc_en         = PCWrite | branch_taken;
    pc_d          = pc_q;
    pcsrc_err_d   = pcsrc_err_q;
    ir_d          = ir_q;
    instr_count_d = instr_count_q;

    if (pc_en) begin
      unique case (PCSource)
        2'd0:    pc_d = alu_result_ext[ADDR_W-1:0];
        2'd1:    pc_d = alu_out_ext[ADDR_W-1:0];
        2'd2:    pc_d = ir_ext[ADDR_W-1:0];
        default: pcsrc_err_d = 1'b1;  // illegal select: hold PC, flag sticks until reset
      endcase
    end

    if (IRWrite) begin
      ir_d          = imem_data;
      instr_count_d = instr_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q          <= ADDR_W'(RESET_PC);
      ir_q          <= '0;
      alu_out_q     <= '0;
      instr_count_q <= '0;
      pcsrc_err_q   <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      alu_out_q     <= alu_result;
      instr_count_q <= instr_count_d;
      pcsrc_err_q   <= pcsrc_err_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign opcode      = ir_q[31:26];
  assign rs          = ir_q[25:21];
  assign rt          = ir_q[20:16];
  assign rd          = ir_q[15:11];
  assign imm         = ir_q[15:0];
  assign alu_out     = alu_out_q;
  assign instr_count = instr_count_q;
  assign pcsrc_err   = pcsrc_err_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: directed scenarios plus random strobes, compared
// against an arithmetic reference model; a second instance checks an 8-bit address width.
module tb_pc_ir_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        PCWrite, PCWriteCond, IRWrite, Instr26, alu_zero;
  logic [1:0]  PCSource;
  logic [31:0] imem_data, alu_result;

  logic [15:0] imem_addr, pc;
  logic [7:0]  imem_addr8, pc8;
  logic [5:0]  opcode, opcode8;
  logic [4:0]  rs, rt, rd, rs8, rt8, rd8;
  logic [15:0] imm, imm8;
  logic [31:0] alu_out, alu_out8, instr_count, instr_count8;
  logic        branch_taken, branch_taken8, pcsrc_err, pcsrc_err8;

  int unsigned total  = 0;
  int unsigned passed = 0;

  // Reference model state
  longint unsigned m_pc16, m_pc8, m_ir, m_aluout, m_cnt;
  bit              m_err;

  always #5 clock = ~clock;

  pc_ir_unit #(.ADDR_W(16), .RESET_PC(0), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .IRWrite(IRWrite), .Instr26(Instr26), .imem_data(imem_data),
    .alu_result(alu_result), .alu_zero(alu_zero), .imem_addr(imem_addr), .pc(pc),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .alu_out(alu_out),
    .branch_taken(branch_taken), .instr_count(instr_count), .pcsrc_err(pcsrc_err)
  );

  pc_ir_unit #(.ADDR_W(8), .RESET_PC(0), .CNT_W(32)) dut8 (
    .clock(clock), .reset(reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .IRWrite(IRWrite), .Instr26(Instr26), .imem_data(imem_data),
    .alu_result(alu_result), .alu_zero(alu_zero), .imem_addr(imem_addr8), .pc(pc8),
    .opcode(opcode8), .rs(rs8), .rt(rt8), .rd(rd8), .imm(imm8), .alu_out(alu_out8),
    .branch_taken(branch_taken8), .instr_count(instr_count8), .pcsrc_err(pcsrc_err8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc16 = 0; m_pc8 = 0; m_ir = 0; m_aluout = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic check_regs(input string where);
    chk({where, " pc"}, pc, m_pc16);
    chk({where, " imem_addr"}, imem_addr, m_pc16);
    chk({where, " pc8"}, pc8, m_pc8);
    chk({where, " opcode"}, opcode, (m_ir >> 26) % 64);
    chk({where, " rs"}, rs, (m_ir >> 21) % 32);
    chk({where, " rt"}, rt, (m_ir >> 16) % 32);
    chk({where, " rd"}, rd, (m_ir >> 11) % 32);
    chk({where, " imm"}, imm, m_ir % 65536);
    chk({where, " alu_out"}, alu_out, m_aluout);
    chk({where, " instr_count"}, instr_count, m_cnt);
    chk({where, " pcsrc_err"}, pcsrc_err, m_err);
    chk({where, " pcsrc_err8"}, pcsrc_err8, m_err);
  endtask

  // One control-FSM cycle: drive strobes, check the combinational decision, clock, check state.
  task automatic step(input string tag, input bit pw, input bit pwc, input int src,
                      input bit irw, input bit i26, input logic [31:0] imd,
                      input logic [31:0] alu, input bit z);
    bit exp_bt, en;
    longint unsigned sel;
    PCWrite = pw; PCWriteCond = pwc; PCSource = 2'(src); IRWrite = irw;
    Instr26 = i26; imem_data = imd; alu_result = alu; alu_zero = z;
    #1;
    exp_bt = pwc && (z != i26);
    chk({tag, " branch_taken"}, branch_taken, exp_bt);
    chk({tag, " branch_taken8"}, branch_taken8, exp_bt);
    en = pw || exp_bt;
    if (en) begin
      if (src == 3) m_err = 1;
      else begin
        if (src == 0) sel = alu;
        else if (src == 1) sel = m_aluout;
        else sel = m_ir;
        m_pc16 = sel % 65536;
        m_pc8  = sel % 256;
      end
    end
    if (irw) begin
      m_ir  = imd;
      m_cnt = (m_cnt + 1) % 64'h1_0000_0000;
    end
    m_aluout = alu;
    @(posedge clock);
    #1;
    check_regs(tag);
  endtask

  initial begin
    reset = 1'b0; PCWrite = 1'b1; PCWriteCond = 1'b0; PCSource = 2'd0; IRWrite = 1'b1;
    Instr26 = 1'b0; alu_zero = 1'b0; imem_data = 32'hFFFF_FFFF; alu_result = 32'h1234;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_regs("reset_hold");

    reset = 1'b1;
    step("to5", 1, 0, 0, 0, 0, 32'h0, 32'h5, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_regs("reset_async");
    #1 reset = 1'b1;

    // Fetch
    step("pc10", 1, 0, 0, 0, 0, 32'h0, 32'h10, 0);
    step("fetch", 1, 0, 0, 1, 0, 32'h48A3_0007, 32'h11, 0);
    chk("fetch opcode_lit", opcode, 6'b010010);
    chk("fetch rs_lit", rs, 5);
    chk("fetch rt_lit", rt, 3);
    chk("fetch pc_lit", pc, 16'h0011);

    // Branch select and sense
    step("br_tgt", 0, 0, 0, 0, 0, 32'h0, 32'h40, 0);
    step("br_z0_nt", 0, 1, 1, 0, 0, 32'h0, 32'h40, 0);
    chk("br_z0_nt pc_lit", pc, 16'h0011);
    step("br_z1", 0, 1, 1, 0, 0, 32'h0, 32'h40, 1);
    chk("br_z1 pc_lit", pc, 16'h0040);
    step("pc_back", 1, 0, 0, 0, 0, 32'h0, 32'h40, 0);
    step("br_nz", 0, 1, 1, 0, 1, 32'h0, 32'h77, 0);
    step("br_nz_hold", 0, 1, 1, 0, 1, 32'h0, 32'h0, 1);

    // Jump (16- and 8-bit address widths)
    step("ld_jmp", 0, 0, 0, 1, 0, 32'h0400_1234, 32'h0, 0);
    step("jump", 1, 0, 2, 0, 0, 32'h0, 32'h0, 0);
    chk("jump pc_lit", pc, 16'h1234);
    chk("jump pc8_lit", pc8, 8'h34);

    // Wrap, illegal select, sticky error
    step("pcffff", 1, 0, 0, 0, 0, 32'h0, 32'hFFFF, 0);
    step("wrap", 1, 0, 0, 0, 0, 32'h0, 32'h1_0000, 0);
    chk("wrap pc_lit", pc, 16'h0000);
    step("pc_pre", 1, 0, 0, 0, 0, 32'h0, 32'h55, 0);
    step("illegal", 1, 0, 3, 0, 0, 32'h0, 32'h99, 0);
    chk("illegal err_lit", pcsrc_err, 1'b1);
    step("sticky", 1, 0, 0, 0, 0, 32'h0, 32'h66, 0);

    // PCWrite dominates a failed branch condition
    step("priority", 1, 1, 0, 0, 0, 32'h0, 32'h22, 0);
    chk("priority pc_lit", pc, 16'h0022);

    // Reset clears the sticky error, then random strobes
    reset = 1'b0;
    #1;
    model_reset();
    check_regs("reset_clr");
    #1 reset = 1'b1;

    for (int i = 0; i < 300; i++) begin
      step("rand", bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           32'($urandom), 32'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
